// File: rtl/slow_multiplication_pkg.sv
// rtl/slow_multiplication_pkg.sv - shared constants for the shift-and-add multiplier
//
// Purpose : holds the default operand width used by the multiplier and its
//           stage sub-module, so both agree on one value.
// Ports   : none (package).

package slow_multiplication_pkg;

    // Default operand width; the multiplier supports 2 to 32 bits.
    localparam int DEFAULT_WIDTH = 6;

endpackage : slow_multiplication_pkg

// File: rtl/slow_multiplication_stage.sv
// rtl/slow_multiplication_stage.sv - one registered shift-and-add stage
//
// Purpose : adds at most one partial product (the multiplicand shifted left by
//           SHIFT) to the running sum, and forwards the multiplicand and the
//           multiplier (shifted right by one) to the next stage.
// Ports   :
//   clk             - rising-edge clock
//   reset           - asynchronous active-high clear of all stage registers
//   enable          - stage captures only when high, otherwise holds
//   in_1_prev       - multiplicand from the previous stage (or the input)
//   in_2_prev       - remaining multiplier bits; bit 0 selects this partial product
//   acc_prev        - running sum from the previous stage
//   in_1_hist       - registered multiplicand
//   in_2_shift_next - registered multiplier shifted right by one
//   acc             - registered running sum

module slow_multiplication_stage
    import slow_multiplication_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     in_1_prev,
    input  logic [WIDTH-1:0]     in_2_prev,
    input  logic [2*WIDTH-1:0]   acc_prev,
    output logic [WIDTH-1:0]     in_1_hist,
    output logic [WIDTH-1:0]     in_2_shift_next,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] partial;

    // Multiplicand is widened before shifting so no high bits are lost.
    always_comb begin
        partial = '0;
        if (in_2_prev[0]) begin
            partial = {{WIDTH{1'b0}}, in_1_prev} << SHIFT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_1_hist       <= '0;
            in_2_shift_next <= '0;
            acc             <= '0;
        end else if (enable) begin
            in_1_hist       <= in_1_prev;
            in_2_shift_next <= in_2_prev >> 1;
            acc             <= acc_prev + partial;
        end
    end

endmodule : slow_multiplication_stage

// File: rtl/slow_multiplication.sv
// rtl/slow_multiplication.sv - pipelined unsigned shift-and-add multiplier
//
// Purpose : computes out = in_1 * in_2 (unsigned, full 2*WIDTH-bit product)
//           through WIDTH register stages, one partial product per stage.
//           Accepts a new operand pair on every enabled cycle; the product
//           appears exactly WIDTH enabled edges later.
// Ports   :
//   clk    - rising-edge clock
//   reset  - asynchronous active-high; clears every stage and out
//   enable - pipeline advance; when low all registers hold
//   in_1   - unsigned multiplicand, WIDTH bits
//   in_2   - unsigned multiplier, WIDTH bits
//   out    - registered unsigned product, 2*WIDTH bits

module slow_multiplication
    import slow_multiplication_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     in_1,
    input  logic [WIDTH-1:0]     in_2,
    output logic [2*WIDTH-1:0]   out
);

    localparam int LAST = WIDTH - 2;
    localparam logic [2*WIDTH-1:0] ZERO_ACC = '0;
    localparam logic [WIDTH-1:0]   LSB_MASK = WIDTH'(1);

    logic [WIDTH-1:0]   in_1_history [0:WIDTH-2];
    logic [WIDTH-1:0]   in_2_shift   [0:WIDTH-2];
    logic [2*WIDTH-1:0] tmp_result   [0:WIDTH-2];

    // Stages 0 .. WIDTH-2; stage k contributes in_1 << k when multiplier bit k is set.
    genvar k;
    generate
        for (k = 0; k <= LAST; k++) begin : g_stage
            if (k == 0) begin : g_first
                slow_multiplication_stage #(
                    .WIDTH (WIDTH),
                    .SHIFT (0)
                ) u_stage (
                    .clk             (clk),
                    .reset           (reset),
                    .enable          (enable),
                    .in_1_prev       (in_1),
                    .in_2_prev       (in_2),
                    .acc_prev        (ZERO_ACC),
                    .in_1_hist       (in_1_history[0]),
                    .in_2_shift_next (in_2_shift[0]),
                    .acc             (tmp_result[0])
                );
            end else begin : g_next
                slow_multiplication_stage #(
                    .WIDTH (WIDTH),
                    .SHIFT (k)
                ) u_stage (
                    .clk             (clk),
                    .reset           (reset),
                    .enable          (enable),
                    .in_1_prev       (in_1_history[k-1]),
                    .in_2_prev       (in_2_shift[k-1]),
                    .acc_prev        (tmp_result[k-1]),
                    .in_1_hist       (in_1_history[k]),
                    .in_2_shift_next (in_2_shift[k]),
                    .acc             (tmp_result[k])
                );
            end
        end
    endgenerate

    // Final stage: only the top multiplier bit remains, so just the sum is kept.
    logic               last_select;
    logic [2*WIDTH-1:0] last_partial;

    always_comb begin
        last_select  = |(in_2_shift[LAST] & LSB_MASK);
        last_partial = '0;
        if (last_select) begin
            last_partial = {{WIDTH{1'b0}}, in_1_history[LAST]} << (WIDTH - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else if (enable) begin
            out <= tmp_result[LAST] + last_partial;
        end
    end

endmodule : slow_multiplication

// File: tb/tb_slow_multiplication.sv
// tb/tb_slow_multiplication.sv - self-checking bench for slow_multiplication

module tb_slow_multiplication;

    localparam int W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [W-1:0]     in_1;
    logic [W-1:0]     in_2;
    logic [2*W-1:0]   out;

    logic [2*W-1:0]   sb [$];
    logic [2*W-1:0]   exp_out;
    int               checks = 0;
    int               errors = 0;

    slow_multiplication #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in_1   (in_1),
        .in_2   (in_2),
        .out    (out)
    );

    always #5 clk = ~clk;

    // Pipeline model: W-1 bubbles of zero ahead of the first sampled product.
    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < W - 1; i++) sb.push_back('0);
        exp_out = '0;
    endtask

    // Drives one cycle from a negedge, updates the model at the posedge and
    // returns at the following negedge, where the caller samples out.
    task automatic drive_cycle(input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
        logic [2*W-1:0] pa;
        logic [2*W-1:0] pb;
        pa = {{W{1'b0}}, a};
        pb = {{W{1'b0}}, b};
        in_1   = a;
        in_2   = b;
        enable = en;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (en) begin
            sb.push_back(pa * pb);
            exp_out = sb.pop_front();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        in_1   = 6'd63;
        in_2   = 6'd63;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold out=%0d expected=0", out);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tb_ [3];
        logic [2*W-1:0] tp [3];
        ta = '{6'd1, 6'd10, 6'd60};
        tb_ = '{6'd10, 6'd12, 6'd40};
        tp = '{12'd10, 12'd120, 12'd2400};
        for (int p = 0; p < 3; p++) begin
            for (int c = 1; c <= 10; c++) begin
                drive_cycle(ta[p], tb_[p], 1'b1);
                checks++;
                if (out !== exp_out) begin
                    errors++;
                    $display("FAIL basic_sb pair=%0d cyc=%0d out=%0d expected=%0d", p, c, out, exp_out);
                end
                if (c == 6) begin
                    checks++;
                    if (out !== tp[p]) begin
                        errors++;
                        $display("FAIL basic_product pair=%0d out=%0d expected=%0d", p, out, tp[p]);
                    end
                end
            end
        end
    endtask

    task automatic test_corner();
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tb_ [3];
        logic [2*W-1:0] tp [3];
        ta = '{6'd63, 6'd0, 6'd63};
        tb_ = '{6'd63, 6'd63, 6'd1};
        tp = '{12'd3969, 12'd0, 12'd63};
        for (int p = 0; p < 3; p++) begin
            for (int c = 1; c <= 8; c++) begin
                drive_cycle(ta[p], tb_[p], 1'b1);
                checks++;
                if (out !== exp_out) begin
                    errors++;
                    $display("FAIL corner_sb pair=%0d cyc=%0d out=%0d expected=%0d", p, c, out, exp_out);
                end
                if (c == 6) begin
                    checks++;
                    if (out !== tp[p]) begin
                        errors++;
                        $display("FAIL corner_product pair=%0d out=%0d expected=%0d", p, out, tp[p]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tb_ [3];
        logic [2*W-1:0] tp [3];
        ta = '{6'd3, 6'd7, 6'd63};
        tb_ = '{6'd5, 6'd9, 6'd2};
        tp = '{12'd15, 12'd63, 12'd126};
        for (int c = 1; c <= 10; c++) begin
            if (c <= 3) drive_cycle(ta[c-1], tb_[c-1], 1'b1);
            else        drive_cycle(6'd0, 6'd0, 1'b1);
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL b2b_sb cyc=%0d out=%0d expected=%0d", c, out, exp_out);
            end
            if (c >= 6 && c <= 8) begin
                checks++;
                if (out !== tp[c-6]) begin
                    errors++;
                    $display("FAIL b2b_product cyc=%0d out=%0d expected=%0d", c, out, tp[c-6]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic           en_pat [12];
        logic [2*W-1:0] prev;
        en_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        prev = out;
        for (int c = 0; c < 12; c++) begin
            if (c == 0)          drive_cycle(6'd11, 6'd13, 1'b1);
            else if (!en_pat[c]) drive_cycle(W'($urandom), W'($urandom), 1'b0);
            else                 drive_cycle(6'd0, 6'd0, 1'b1);
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL stall_sb cyc=%0d out=%0d expected=%0d", c, out, exp_out);
            end
            if (!en_pat[c]) begin
                checks++;
                if (out !== prev) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d out=%0d expected=%0d", c, out, prev);
                end
            end
            if (c == 8) begin
                checks++;
                if (out !== 12'd143) begin
                    errors++;
                    $display("FAIL stall_product out=%0d expected=143", out);
                end
            end
            prev = out;
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 7; c++) drive_cycle(6'd50, 6'd50, 1'b1);
        checks++;
        if (out !== 12'd2500) begin
            errors++;
            $display("FAIL pre_reset_product out=%0d expected=2500", out);
        end
        drive_cycle(6'd33, 6'd21, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out !== 12'd0) begin
            errors++;
            $display("FAIL reset_async out=%0d expected=0", out);
        end
        @(negedge clk);
        checks++;
        if (out !== 12'd0) begin
            errors++;
            $display("FAIL reset_held out=%0d expected=0", out);
        end
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) drive_cycle(6'd9, 6'd7, 1'b1);
            else        drive_cycle(6'd0, 6'd0, 1'b1);
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL post_reset_sb cyc=%0d out=%0d expected=%0d", c, out, exp_out);
            end
            if (c < 6) begin
                checks++;
                if (out !== 12'd0) begin
                    errors++;
                    $display("FAIL post_reset_zero cyc=%0d out=%0d expected=0", c, out);
                end
            end
            if (c == 6) begin
                checks++;
                if (out !== 12'd63) begin
                    errors++;
                    $display("FAIL post_reset_product out=%0d expected=63", out);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 80; c++) begin
            drive_cycle(W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0));
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL random_sb cyc=%0d out=%0d expected=%0d", c, out, exp_out);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        in_1   = '0;
        in_2   = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_corner();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_slow_multiplication
